// File: rtl/sram_fb_reader_pkg.sv
// Shared framebuffer geometry, bus widths and reader FSM states.
// The default geometry matches the SRAM clear block and the VGA timing block.
package sram_fb_reader_pkg;

  localparam int DEFAULT_FB_W       = 640;
  localparam int DEFAULT_FB_H       = 480;
  localparam int DEFAULT_FIFO_DEPTH = 16;
  localparam int FB_ADDR_W          = 20;
  localparam int PIX_W              = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } rd_state_t;

endpackage

// File: rtl/sram_rd_fifo.sv
// Synchronous show-ahead FIFO holding prefetched framebuffer words.
// The head word is always visible on dout; dout reads 0 while the FIFO is empty.
module sram_rd_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sram_fb_reader.sv
// Framebuffer scan-out reader: streams the framebuffer from async SRAM into a
// show-ahead FIFO drained by the pixel pipeline; releases the bus when enable=0.
module sram_fb_reader
  import sram_fb_reader_pkg::*;
#(
  parameter int FB_W       = DEFAULT_FB_W,
  parameter int FB_H       = DEFAULT_FB_H,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                 clk50,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 frame_start,
  input  logic                 pix_ready,
  output logic [PIX_W-1:0]     pix_data,
  output logic                 pix_valid,
  output logic                 frame_done,
  output logic                 underflow,
  output logic [FB_ADDR_W-1:0] SRAM_ADDR,
  input  logic [PIX_W-1:0]     SRAM_DQ,
  output logic                 SRAM_CE_N,
  output logic                 SRAM_OE_N,
  output logic                 SRAM_WE_N,
  output logic                 SRAM_UB_N,
  output logic                 SRAM_LB_N
);

  localparam int FB_PIXELS = FB_W * FB_H;
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FB_PIXELS - 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CREDITS = CW'(FIFO_DEPTH);

  rd_state_t            state;
  logic [FB_ADDR_W-1:0] addr;
  logic [FB_ADDR_W-1:0] sram_addr_q;
  logic                 inflight;
  logic                 last_issued;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 issue;
  logic                 capture;
  logic                 pop;

  // A read is only issued when its word is guaranteed a FIFO slot on arrival.
  assign issue   = (state == ST_FILL) && enable && !last_issued && !fifo_full &&
                   ((fifo_count + CW'(inflight)) < CREDITS);
  assign capture = inflight && enable && !frame_start;
  assign pop     = pix_ready && !fifo_empty && !frame_start;
  assign pix_valid = !fifo_empty;

  assign SRAM_ADDR = enable ? sram_addr_q : 'z;
  assign SRAM_CE_N = enable ? 1'b0 : 1'bz;
  assign SRAM_OE_N = enable ? 1'b0 : 1'bz;
  assign SRAM_WE_N = enable ? 1'b1 : 1'bz;
  assign SRAM_UB_N = enable ? 1'b0 : 1'bz;
  assign SRAM_LB_N = enable ? 1'b0 : 1'bz;

  // frame_start also issues address 0 on the same edge so word 0 lands one edge later.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      addr        <= '0;
      sram_addr_q <= '0;
      inflight    <= 1'b0;
      last_issued <= 1'b0;
      frame_done  <= 1'b0;
      underflow   <= 1'b0;
    end else if (frame_start) begin
      state       <= ST_FILL;
      sram_addr_q <= '0;
      inflight    <= enable;
      addr        <= enable ? FB_ADDR_W'(1) : '0;
      last_issued <= 1'b0;
      frame_done  <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (pix_ready && fifo_empty && state == ST_FILL) underflow <= 1'b1;
      if (state == ST_FILL) begin
        if (inflight && !enable) begin
          // Bus was released under the read: drop it and re-issue the same address later.
          inflight    <= 1'b0;
          addr        <= sram_addr_q;
          last_issued <= 1'b0;
        end else if (issue) begin
          sram_addr_q <= addr;
          inflight    <= 1'b1;
          if (addr == LAST_ADDR) last_issued <= 1'b1;
          else                   addr        <= addr + 1'b1;
        end else if (capture) begin
          inflight <= 1'b0;
          if (last_issued) begin
            state      <= ST_DONE;
            frame_done <= 1'b1;
          end
        end
      end
    end
  end

  sram_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PIX_W)
  ) u_fifo (
    .clk   (clk50),
    .rst   (rst),
    .flush (frame_start),
    .push  (capture),
    .pop   (pop),
    .din   (SRAM_DQ),
    .dout  (pix_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_sram_fb_reader.sv
// Scoreboard bench for sram_fb_reader on a reduced 64x100 frame; the SRAM
// model returns the low address bits, so every popped word equals its address.
module tb_sram_fb_reader;

  localparam int TB_W      = 64;
  localparam int TB_H      = 100;
  localparam int TB_PIXELS = TB_W * TB_H;

  logic        clk50 = 1'b0;
  logic        rst;
  logic        enable;
  logic        frame_start;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        frame_done;
  logic        underflow;
  wire  [19:0] sram_addr;
  wire  [15:0] sram_dq;
  wire         sram_ce_n;
  wire         sram_oe_n;
  wire         sram_we_n;
  wire         sram_ub_n;
  wire         sram_lb_n;

  int compared   = 0;
  int mismatched = 0;
  logic [15:0] exp_q[$];

  // Weak pulls make a released bus read back as a value the DUT never drives.
  for (genvar i = 0; i < 20; i++) begin : g_addr_pu
    pullup (sram_addr[i]);
  end
  pullup   (sram_ce_n);
  pullup   (sram_oe_n);
  pulldown (sram_we_n);
  pullup   (sram_ub_n);
  pullup   (sram_lb_n);

  assign sram_dq = sram_addr[15:0];

  always #10 clk50 = ~clk50;

  sram_fb_reader #(
    .FB_W       (TB_W),
    .FB_H       (TB_H),
    .FIFO_DEPTH (16)
  ) dut (
    .clk50       (clk50),
    .rst         (rst),
    .enable      (enable),
    .frame_start (frame_start),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .frame_done  (frame_done),
    .underflow   (underflow),
    .SRAM_ADDR   (sram_addr),
    .SRAM_DQ     (sram_dq),
    .SRAM_CE_N   (sram_ce_n),
    .SRAM_OE_N   (sram_oe_n),
    .SRAM_WE_N   (sram_we_n),
    .SRAM_UB_N   (sram_ub_n),
    .SRAM_LB_N   (sram_lb_n)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rdy, input logic fs);
    enable      = en;
    pix_ready   = rdy;
    frame_start = fs;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  task automatic expectNewFrame();
    exp_q.delete();
    for (int i = 0; i < TB_PIXELS; i++) exp_q.push_back(16'(i));
  endtask

  // Monitor: every accepted handshake must match the next expected word.
  always @(negedge clk50) begin
    if (!rst && !frame_start && pix_valid && pix_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_pop: got %0d, expected no pop", pix_data);
      end else begin
        checkOutput("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int n;

    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(2);
    checkOutput("rst_pix_valid",  32'(pix_valid),  32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_underflow",  32'(underflow),  32'd0);
    checkOutput("rst_pix_data",   32'(pix_data),   32'd0);
    checkOutput("rst_addr",       32'(sram_addr),  32'd0);
    checkOutput("rst_ce_n",       32'(sram_ce_n),  32'd0);
    checkOutput("rst_we_n",       32'(sram_we_n),  32'd1);
    rst = 1'b0;
    tick(1);
    pix_ready = 1'b1;
    tick(3);
    checkOutput("idle_underflow", 32'(underflow), 32'd0);
    checkOutput("idle_pix_valid", 32'(pix_valid), 32'd0);

    $display("[TB] full frame, consumer always ready");
    expectNewFrame();
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick(1);
    frame_start = 1'b0;
    checkOutput("t1_valid_after_e0", 32'(pix_valid), 32'd0);
    tick(1);
    checkOutput("t1_valid_after_e1", 32'(pix_valid), 32'd1);
    checkOutput("t1_first_word",     32'(pix_data),  32'd0);
    n = 0;
    while (!frame_done && n < TB_PIXELS + 500) begin
      tick(1);
      n++;
    end
    checkOutput("t1_done_cycles", 32'(n), 32'(TB_PIXELS - 1));
    tick(3);
    checkOutput("t1_drained",     32'(exp_q.size()), 32'd0);
    checkOutput("t1_valid_empty", 32'(pix_valid),    32'd0);
    checkOutput("t1_done_held",   32'(frame_done),   32'd1);

    $display("[TB] backpressure fills FIFO");
    expectNewFrame();
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick(1);
    frame_start = 1'b0;
    checkOutput("t2_done_cleared", 32'(frame_done), 32'd0);
    tick(30);
    checkOutput("t2_addr_stop", 32'(sram_addr),     32'd15);
    checkOutput("t2_valid",     32'(pix_valid),     32'd1);
    checkOutput("t2_head",      32'(pix_data),      32'd0);
    checkOutput("t2_no_pops",   32'(exp_q.size()),  32'(TB_PIXELS));
    pix_ready = 1'b1;

    $display("[TB] bus release at address 100");
    n = 0;
    while (sram_addr != 20'd100 && n < 300) begin
      tick(1);
      n++;
    end
    checkOutput("t3_reach_100", 32'(sram_addr), 32'd100);
    enable = 1'b0;
    tick(1);
    checkOutput("t3_addr_z", 32'(sram_addr), 32'hFFFFF);
    checkOutput("t3_ce_z",   32'(sram_ce_n), 32'd1);
    checkOutput("t3_oe_z",   32'(sram_oe_n), 32'd1);
    checkOutput("t3_we_z",   32'(sram_we_n), 32'd0);
    checkOutput("t3_ub_z",   32'(sram_ub_n), 32'd1);
    checkOutput("t3_lb_z",   32'(sram_lb_n), 32'd1);
    tick(4);
    enable = 1'b1;
    tick(1);
    checkOutput("t3_reissue", 32'(sram_addr), 32'd100);

    $display("[TB] restart mid-frame at address 5000");
    n = 0;
    while (sram_addr != 20'd5000 && n < TB_PIXELS) begin
      tick(1);
      n++;
    end
    checkOutput("t5_reach_5000", 32'(sram_addr), 32'd5000);
    expectNewFrame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    checkOutput("t5_valid_drop", 32'(pix_valid), 32'd0);
    checkOutput("t5_addr_zero",  32'(sram_addr), 32'd0);
    tick(30);

    $display("[TB] underflow is sticky during FILL");
    expectNewFrame();
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick(1);
    frame_start = 1'b0;
    checkOutput("t4_cleared_by_start", 32'(underflow), 32'd0);
    pix_ready = 1'b1;
    tick(1);
    checkOutput("t4_set", 32'(underflow), 32'd1);
    pix_ready = 1'b0;
    tick(10);
    checkOutput("t4_sticky",  32'(underflow),    32'd1);
    checkOutput("t4_no_pops", 32'(exp_q.size()), 32'(TB_PIXELS));
    pix_ready = 1'b1;
    tick(20);
    expectNewFrame();
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick(1);
    frame_start = 1'b0;
    checkOutput("t4_clear_next_start", 32'(underflow), 32'd0);
    checkOutput("t4_flush_wins",       32'(pix_valid), 32'd0);

    $display("[TB] asynchronous reset mid-frame");
    tick(50);
    #5;
    rst = 1'b1;
    #1;
    checkOutput("t6_pix_valid",  32'(pix_valid),  32'd0);
    checkOutput("t6_pix_data",   32'(pix_data),   32'd0);
    checkOutput("t6_frame_done", 32'(frame_done), 32'd0);
    checkOutput("t6_underflow",  32'(underflow),  32'd0);
    checkOutput("t6_addr",       32'(sram_addr),  32'd0);
    exp_q.delete();
    tick(2);
    rst = 1'b0;
    tick(20);
    checkOutput("t6_idle_valid",     32'(pix_valid), 32'd0);
    checkOutput("t6_idle_addr",      32'(sram_addr), 32'd0);
    checkOutput("t6_idle_underflow", 32'(underflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
